// File: rtl/axi4_wr_aux_gen_no_resp.sv
// AXI4 write-address generator: one descriptor -> one AW burst,
// then opens the W-path valve until the burst's wlast beat completes.
module axi4_wr_aux_gen_no_resp #(
  parameter int IDSIZE = 4,
  parameter int ASIZE  = 32,
  parameter int LSIZE  = 9,
  parameter int DSIZE  = 32
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [IDSIZE+ASIZE+LSIZE-1:0] id_add_len_in_tdata,
  input  logic                          id_add_len_in_tvalid,
  input  logic                          id_add_len_in_tlast,
  output logic                          id_add_len_in_tready,
  output logic [IDSIZE-1:0]             axi_awid,
  output logic [ASIZE-1:0]              axi_awaddr,
  output logic [LSIZE-1:0]              axi_awlen,
  output logic [2:0]                    axi_awsize,
  output logic [1:0]                    axi_awburst,
  output logic                          axi_awvalid,
  input  logic                          axi_awready,
  input  logic                          axi_wvalid,
  input  logic                          axi_wready,
  input  logic                          axi_wlast,
  output logic                          stream_en
);

  localparam int DW = IDSIZE + ASIZE + LSIZE;
  localparam logic [2:0] AWSIZE =
    3'($clog2(DSIZE / 8));

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t state, state_n;

  logic tready_q;
  logic awvalid_q;
  logic stream_en_q;
  logic desc_hs;
  logic aw_hs;
  logic w_last_hs;
  logic unused_tlast;

  assign unused_tlast = id_add_len_in_tlast;

  assign desc_hs   = id_add_len_in_tvalid & tready_q;
  assign aw_hs     = awvalid_q & axi_awready;
  assign w_last_hs = axi_wvalid & axi_wready
                   & axi_wlast;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (desc_hs) state_n = ADDR;
      ADDR: if (aw_hs) state_n = DATA;
      DATA: if (w_last_hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are flopped from next state so they
  // leave reset at 0 and come up glitch-free.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state       <= IDLE;
      tready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      stream_en_q <= 1'b0;
      axi_awid    <= '0;
      axi_awaddr  <= '0;
      axi_awlen   <= '0;
    end else begin
      state       <= state_n;
      tready_q    <= (state_n == IDLE);
      awvalid_q   <= (state_n == ADDR);
      stream_en_q <= (state_n == DATA);
      if (desc_hs) begin
        axi_awid   <= id_add_len_in_tdata[DW-1 -: IDSIZE];
        axi_awaddr <= id_add_len_in_tdata[LSIZE +: ASIZE];
        axi_awlen  <= id_add_len_in_tdata[LSIZE-1:0];
      end
    end
  end

  assign id_add_len_in_tready = tready_q;
  assign axi_awvalid          = awvalid_q;
  assign stream_en            = stream_en_q;
  assign axi_awsize           = AWSIZE;
  assign axi_awburst          = 2'b01;

endmodule

// File: tb/tb_axi4_wr_aux_gen_no_resp.sv
// Bench for axi4_wr_aux_gen_no_resp: directed scenarios plus
// random traffic checked against a transaction-level model.
module tb_axi4_wr_aux_gen_no_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [44:0] tdata;
  logic        tvalid, tlast, tready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [8:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic        wvalid, wready, wlast;
  logic        stream_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_wr_aux_gen_no_resp dut (
    .axi_aclk             (clk),
    .axi_aresetn          (rst_n),
    .id_add_len_in_tdata  (tdata),
    .id_add_len_in_tvalid (tvalid),
    .id_add_len_in_tlast  (tlast),
    .id_add_len_in_tready (tready),
    .axi_awid             (awid),
    .axi_awaddr           (awaddr),
    .axi_awlen            (awlen),
    .axi_awsize           (awsize),
    .axi_awburst          (awburst),
    .axi_awvalid          (awvalid),
    .axi_awready          (awready),
    .axi_wvalid           (wvalid),
    .axi_wready           (wready),
    .axi_wlast            (wlast),
    .stream_en            (stream_en)
  );

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, got, exp, $time);
    end
  endtask

  // Transaction-level model: a burst is either waiting
  // for its AW, streaming data, or absent.
  bit         m_aw, m_dat, m_rdy;
  bit [3:0]   m_id;
  bit [31:0]  m_addr;
  bit [8:0]   m_len;
  bit [3:0]   id_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_aw = 0; m_dat = 0; m_rdy = 0;
      m_id = 0; m_addr = 0; m_len = 0;
      id_q.delete();
    end else begin
      if (m_rdy && tvalid) begin
        m_id   = tdata[44:41];
        m_addr = tdata[40:9];
        m_len  = tdata[8:0];
        m_aw   = 1;
        id_q.push_back(tdata[44:41]);
      end else if (m_aw && awready) begin
        m_aw  = 0;
        m_dat = 1;
      end else if (m_dat && wvalid && wready && wlast) begin
        m_dat = 0;
      end
      m_rdy = !m_aw && !m_dat;
    end
  end

  always @(negedge clk) begin
    chk("tready", tready, m_rdy);
    chk("awvalid", awvalid, m_aw);
    chk("stream_en", stream_en, m_dat);
    chk("awid", awid, m_id);
    chk("awaddr", awaddr, m_addr);
    chk("awlen", awlen, m_len);
    chk("awsize", awsize, 3'd2);
    chk("awburst", awburst, 2'b01);
    if (rst_n && awvalid && awready) begin
      if (id_q.size() == 0) chk("aw_order_empty", 1, 0);
      else chk("aw_order", awid, id_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [44:0] desc(input int id,
                                       input int addr,
                                       input int len);
    return {4'(id), 32'(addr), 9'(len)};
  endfunction

  task automatic w_idle();
    wvalid = 0; wready = 0; wlast = 0;
  endtask

  initial begin
    rst_n = 0; tvalid = 1; tlast = 0; awready = 0;
    tdata = desc(5, 32'h55, 7);
    w_idle();
    repeat (3) step();
    #1;
    chk("rst_tready", tready, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_stream_en", stream_en, 0);
    tvalid = 0;
    rst_n = 1;
    step();
    #1 chk("post_rst_tready", tready, 1);

    // single 16-beat burst
    tdata = desc(3, 32'h1000_0000, 15); tvalid = 1;
    step();
    tvalid = 0; awready = 1;
    #1;
    chk("s_awvalid", awvalid, 1);
    chk("s_awid", awid, 3);
    chk("s_awaddr", awaddr, 32'h1000_0000);
    chk("s_awlen", awlen, 15);
    step();
    awready = 0;
    #1;
    chk("s_awvalid_drop", awvalid, 0);
    chk("s_stream_en", stream_en, 1);
    for (int i = 0; i < 16; i++) begin
      wvalid = 1; wready = 1; wlast = (i == 15);
      step();
      #1 chk("s_beat_en", stream_en, i < 15);
    end
    w_idle();

    // AW back-pressure, then W stall with wlast held
    tdata = desc(9, 32'h2000, 2); tvalid = 1;
    step();
    tvalid = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk("bp_awvalid", awvalid, 1);
      chk("bp_awaddr", awaddr, 32'h2000);
      chk("bp_en", stream_en, 0);
      chk("bp_tready", tready, 0);
    end
    awready = 1;
    step();
    awready = 0;
    #1 chk("bp_en_up", stream_en, 1);
    wvalid = 1; wready = 0; wlast = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      #1 chk("stall_en", stream_en, 1);
    end
    wready = 1;
    step();
    w_idle();
    #1 chk("stall_done", stream_en, 0);

    // back-to-back descriptors
    awready = 1;
    tdata = desc(1, 0, 0); tvalid = 1;
    step();
    tdata = desc(2, 32'h40, 3);
    #1;
    chk("bb_awid1", awid, 1);
    chk("bb_tready0", tready, 0);
    step();
    wvalid = 1; wready = 1; wlast = 1;
    #1 chk("bb_hold", tready, 0);
    step();
    w_idle();
    #1;
    chk("bb_tready1", tready, 1);
    chk("bb_awid_keep", awid, 1);
    step();
    tvalid = 0;
    #1;
    chk("bb_awid2", awid, 2);
    chk("bb_awaddr2", awaddr, 32'h40);
    step();
    wvalid = 1; wready = 1; wlast = 1;
    step();
    w_idle();
    awready = 0;

    // reset mid-DATA
    tdata = desc(6, 32'h600, 4); tvalid = 1;
    step();
    tvalid = 0; awready = 1;
    step();
    awready = 0;
    #1 chk("md_en", stream_en, 1);
    rst_n = 0;
    #1;
    chk("md_rst_en", stream_en, 0);
    chk("md_rst_awvalid", awvalid, 0);
    step();
    rst_n = 1;
    step();
    tdata = desc(7, 32'h700, 1); tvalid = 1;
    step();
    tvalid = 0;
    #1;
    chk("md_new_awid", awid, 7);
    chk("md_new_awvalid", awvalid, 1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      tvalid  = ($urandom_range(0, 3) != 0);
      tdata   = desc($urandom, $urandom,
                     $urandom_range(0, 511));
      tlast   = $urandom_range(0, 1);
      awready = $urandom_range(0, 1);
      wvalid  = $urandom_range(0, 1);
      wready  = $urandom_range(0, 1);
      wlast   = ($urandom_range(0, 3) == 0);
    end
    step();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
